// File: rtl/keypad_encoder8_if.sv
// Key-line and encoded-key bundle between the keypad encoder and its consumer.
// master = encoder side, slave = control logic / board side.
interface keypad_encoder8_if;
   logic [7:0] btn_n;
   logic [2:0] key_code;
   logic       key_valid;
   logic       key_release;
   logic       key_held;
   logic       key_multi;

   modport master (
      input  btn_n,
      output key_code, key_valid, key_release, key_held, key_multi
   );

   modport slave (
      output btn_n,
      input  key_code, key_valid, key_release, key_held, key_multi
   );
endinterface

// File: rtl/keypad_encoder8.sv
// Debounced priority encoder for eight active-low key lines: synchronise,
// debounce press and release, report lowest-numbered pressed key.

// Two-flop synchroniser for one key line; idles high (key released).
module keypad_sync_bit (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic q_out
);
   logic meta_q, meta_d;
   logic sync_q, sync_d;

   always_comb begin
      meta_d = d_in;
      sync_d = meta_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
      end else begin
         meta_q <= meta_d;
         sync_q <= sync_d;
      end
   end

   assign q_out = sync_q;
endmodule

module keypad_encoder8 #(
   parameter int DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic               clk,
   input  logic               rst_n,
   keypad_encoder8_if.master  kp
);
   localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {IDLE, ARM, PRESSED, RELEASE} state_t;

   typedef struct packed {
      logic [2:0] code;
      logic       valid;
      logic       rls;
      logic       held;
      logic       multi;
   } key_out_t;

   logic [7:0]       btn_s;
   state_t           state_q, state_d;
   logic [7:0]       snap_q, snap_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   key_out_t         out_q, out_d;
   logic             all_high;
   logic [2:0]       snap_code;
   logic [3:0]       snap_zeros;
   logic             snap_multi;

   for (genvar i = 0; i < 8; i++) begin : g_sync
      keypad_sync_bit u_sync (
         .clk   (clk),
         .rst_n (rst_n),
         .d_in  (kp.btn_n[i]),
         .q_out (btn_s[i])
      );
   end

   assign all_high = (btn_s == 8'hFF);

   // Scan high-to-low so the lowest-numbered pressed key overwrites last.
   always_comb begin
      snap_code  = 3'd0;
      snap_zeros = 4'd0;
      for (int i = 7; i >= 0; i--) begin
         if (!snap_q[i]) begin
            snap_code  = 3'(i);
            snap_zeros = snap_zeros + 4'd1;
         end
      end
      snap_multi = (snap_zeros > 4'd1);
   end

   always_comb begin
      state_d   = state_q;
      snap_d    = snap_q;
      cnt_d     = cnt_q;
      out_d     = out_q;
      out_d.valid = 1'b0;
      out_d.rls   = 1'b0;
      case (state_q)
         IDLE: begin
            if (!all_high) begin
               snap_d  = btn_s;
               cnt_d   = '0;
               state_d = ARM;
            end
         end
         ARM: begin
            if (all_high) begin
               state_d = IDLE;
            end else if (btn_s != snap_q) begin
               // Any pattern change restarts the debounce window.
               snap_d = btn_s;
               cnt_d  = '0;
            end else if (cnt_q == CNT_LAST) begin
               state_d     = PRESSED;
               out_d.code  = snap_code;
               out_d.multi = snap_multi;
               out_d.valid = 1'b1;
               out_d.held  = 1'b1;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         PRESSED: begin
            if (all_high) begin
               cnt_d   = '0;
               state_d = RELEASE;
            end
         end
         RELEASE: begin
            if (!all_high) begin
               state_d = PRESSED;
            end else if (cnt_q == CNT_LAST) begin
               state_d    = IDLE;
               out_d.rls  = 1'b1;
               out_d.held = 1'b0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         snap_q  <= 8'hFF;
         cnt_q   <= '0;
         out_q   <= '0;
      end else begin
         state_q <= state_d;
         snap_q  <= snap_d;
         cnt_q   <= cnt_d;
         out_q   <= out_d;
      end
   end

   assign kp.key_code    = out_q.code;
   assign kp.key_valid   = out_q.valid;
   assign kp.key_release = out_q.rls;
   assign kp.key_held    = out_q.held;
   assign kp.key_multi   = out_q.multi;
endmodule
